// File: rtl/print_job_queue_pkg.sv
// Shared types for the print job path: dispatch FSM states, printer status
// encodings and the default page-count width.
package print_pkg;

  localparam int DEFAULT_PAGE_W = 8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_t;

  // Encodings of the printer controller's own state, kept in one place for both blocks
  typedef logic [1:0] prn_status_t;
  localparam prn_status_t SLEEPING = 2'd0;
  localparam prn_status_t WARMING  = 2'd1;
  localparam prn_status_t LOADING  = 2'd2;
  localparam prn_status_t PRINTING = 2'd3;

  function automatic logic printer_idle(input logic warm, input logic loadpage,
                                        input logic printpage);
    return ~(warm | loadpage | printpage);
  endfunction

endpackage

// File: rtl/print_job_queue_if.sv
// Job intake handshake plus the printer push/status link.
// master = job source and printer side, slave = print_job_queue.
interface print_job_queue_if #(
  parameter int PAGE_W = print_pkg::DEFAULT_PAGE_W
) ();

  logic              job_valid;
  logic [PAGE_W-1:0] job_pages;
  logic              job_ready;
  logic              warm;
  logic              loadpage;
  logic              printpage;
  logic              push;
  logic [PAGE_W-1:0] pages;

  modport master (
    output job_valid, job_pages, warm, loadpage, printpage,
    input  job_ready, push, pages
  );

  modport slave (
    input  job_valid, job_pages, warm, loadpage, printpage,
    output job_ready, push, pages
  );

endinterface

// File: rtl/print_job_queue_job_fifo.sv
// Synchronous FIFO of page counts; pointers carry an extra wrap bit so
// full and empty are distinguishable without a separate counter.
module job_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;

  assign count   = wr_ptr_r - rd_ptr_r;
  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign rd_data = mem_r[rd_ptr_r[AW-1:0]];

  // Storage and pointers; writes to a full FIFO and reads from an empty one are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (wr_en && !full) begin
        mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        wr_ptr_r                <= wr_ptr_r + PTR_ONE;
      end
      if (rd_en && !empty) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/print_job_queue.sv
// Buffers print jobs and dispatches them one at a time to the printer
// controller, tracking start/completion, start timeouts and printed pages.
module print_job_queue
  import print_pkg::*;
#(
  parameter  int DEPTH         = 4,
  parameter  int PAGE_W        = DEFAULT_PAGE_W,
  parameter  int START_TIMEOUT = 255,
  parameter  int CNT_W         = 16,
  localparam int QW            = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  print_job_queue_if.slave    bus,
  output logic [QW-1:0]       queued,
  output logic                job_done,
  output logic                start_err,
  output logic                zero_job,
  output logic [CNT_W-1:0]    pages_printed
);

  localparam int          TW      = $clog2(START_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(START_TIMEOUT - 1);

  state_t              state_r;
  logic                push_r;
  logic [PAGE_W-1:0]   pages_r;
  logic [TW-1:0]       tmo_r;
  logic                job_done_r;
  logic                start_err_r;
  logic                zero_job_r;
  logic [CNT_W-1:0]    pages_printed_r;

  logic                full_s;
  logic                empty_s;
  logic [PAGE_W-1:0]   head_s;
  logic                accept_s;
  logic                zero_pages_s;
  logic                idle_s;

  assign accept_s     = bus.job_valid & ~full_s;
  assign zero_pages_s = (bus.job_pages == {PAGE_W{1'b0}});
  assign idle_s       = printer_idle(bus.warm, bus.loadpage, bus.printpage);

  job_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PAGE_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (accept_s & ~zero_pages_s),
    .wr_data (bus.job_pages),
    .rd_en   (state_r == ISSUE),
    .rd_data (head_s),
    .full    (full_s),
    .empty   (empty_s),
    .count   (queued)
  );

  assign bus.job_ready = ~full_s;
  assign bus.push      = push_r;
  assign bus.pages     = pages_r;
  assign job_done      = job_done_r;
  assign start_err     = start_err_r;
  assign zero_job      = zero_job_r;
  assign pages_printed = pages_printed_r;

  // Dispatch FSM with registered push/pages and completion/timeout pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      push_r      <= 1'b0;
      pages_r     <= {PAGE_W{1'b0}};
      tmo_r       <= {TW{1'b0}};
      job_done_r  <= 1'b0;
      start_err_r <= 1'b0;
    end else begin
      push_r      <= 1'b0;
      job_done_r  <= 1'b0;
      start_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!empty_s && idle_s) begin
            state_r <= ISSUE;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          push_r  <= 1'b1;
          pages_r <= head_s;
          tmo_r   <= {TW{1'b0}};
          state_r <= WAIT_START;
        end
        WAIT_START: begin
          // Any printer activity after the push counts as the job having started
          if (!idle_s) begin
            state_r <= WAIT_DONE;
          end else if (tmo_r == TO_LAST) begin
            start_err_r <= 1'b1;
            state_r     <= IDLE;
          end else begin
            tmo_r <= tmo_r + {{(TW-1){1'b0}}, 1'b1};
          end
        end
        WAIT_DONE: begin
          if (idle_s) begin
            job_done_r <= 1'b1;
            state_r    <= IDLE;
          end else begin
            state_r <= WAIT_DONE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Zero-page discard pulse and free-running printed-page counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_job_r      <= 1'b0;
      pages_printed_r <= {CNT_W{1'b0}};
    end else begin
      zero_job_r <= accept_s & zero_pages_s;
      if (bus.printpage) begin
        pages_printed_r <= pages_printed_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        pages_printed_r <= pages_printed_r;
      end
    end
  end

endmodule

// File: tb/tb_print_job_queue.sv
// Scoreboard bench: stimulus queues expected dispatches, a monitor checks
// every cycle against a queue/counter model and a behavioural printer.
module tb_print_job_queue;
  import print_pkg::*;

  localparam int DEPTH = 4;
  localparam int PAGE_W = 8;
  localparam int START_TIMEOUT = 255;
  localparam int CNT_W = 16;
  localparam int QW = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [QW-1:0] queued;
  logic job_done, start_err, zero_job;
  logic [CNT_W-1:0] pages_printed;

  print_job_queue_if #(.PAGE_W(PAGE_W)) bus ();

  print_job_queue #(
    .DEPTH(DEPTH), .PAGE_W(PAGE_W), .START_TIMEOUT(START_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .queued(queued), .job_done(job_done),
    .start_err(start_err), .zero_job(zero_job), .pages_printed(pages_printed)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int exp_q[$];
  int accepted_nz = 0;
  int dispatched = 0;
  bit zero_due = 1'b0;
  bit outstanding = 1'b0;
  bit exp_err = 1'b0;
  int cyc = 0;
  int push_cyc = 0;
  bit prev_push = 1'b0;
  bit prev_idle = 1'b1;
  int exp_pp = 0;
  int last_pages = 0;
  bit mon_en = 1'b0;

  // Printer model controls
  bit silent = 1'b0;
  bit force_busy = 1'b0;
  int pr_ph = 0;
  int pr_cnt = 0;
  int pr_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural printer: after a push it warms, then loads/prints each page
  initial begin
    bus.warm = 1'b0; bus.loadpage = 1'b0; bus.printpage = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pr_ph = 0;
      end else begin
        case (pr_ph)
          0: if (bus.push && !silent) begin pr_ph = 1; pr_cnt = 2; pr_left = int'(bus.pages); end
          1: begin pr_cnt--; if (pr_cnt == 0) begin pr_ph = 2; pr_cnt = 2; end end
          2: begin pr_cnt--; if (pr_cnt == 0) pr_ph = 3; end
          3: pr_ph = 4;
          4: begin pr_left--; pr_ph = (pr_left == 0) ? 0 : 3; end
          default: pr_ph = 0;
        endcase
      end
      bus.warm      = (pr_ph == 2) || force_busy;
      bus.loadpage  = (pr_ph == 3);
      bus.printpage = (pr_ph == 4);
    end
  end

  // Monitor: compares DUT outputs with the model once per cycle
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || !mon_en) begin
        prev_push = 1'b0;
        prev_idle = 1'b1;
        continue;
      end
      cyc++;
      if (bus.printpage) exp_pp++;
      check("pages_printed", pages_printed, exp_pp % (1 << CNT_W));
      if (bus.push) begin
        check("push_back_to_back", prev_push, 0);
        check("dispatch_while_busy", prev_idle, 1);
        check("push_while_outstanding", outstanding, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_push", 1, 0);
        end else begin
          last_pages = exp_q.pop_front();
          check("push_pages", bus.pages, last_pages);
        end
        outstanding = 1'b1;
        exp_err = silent;
        push_cyc = cyc;
        dispatched++;
      end else begin
        check("pages_hold", bus.pages, last_pages);
      end
      check("queued", queued, accepted_nz - dispatched);
      check("job_ready", bus.job_ready, (accepted_nz - dispatched) != DEPTH);
      check("zero_job", zero_job, zero_due);
      zero_due = 1'b0;
      if (job_done) begin
        check("job_done_expected", outstanding && !exp_err, 1);
        outstanding = 1'b0;
      end
      if (start_err) begin
        check("start_err_expected", outstanding && exp_err, 1);
        check("start_err_latency", cyc - push_cyc, START_TIMEOUT);
        outstanding = 1'b0;
      end
      prev_push = bus.push;
      prev_idle = !(bus.warm || bus.loadpage || bus.printpage);
    end
  end

  task automatic enqueue(input int p);
    int w;
    @(negedge clk);
    bus.job_valid = 1'b1;
    bus.job_pages = PAGE_W'(p);
    w = 0;
    while (!bus.job_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (!bus.job_ready) begin
      check("enqueue_timeout", 1, 0);
    end else if (p == 0) begin
      zero_due = 1'b1;
    end else begin
      exp_q.push_back(p);
      accepted_nz++;
    end
    @(posedge clk);
    #1 bus.job_valid = 1'b0;
  endtask

  task automatic wait_quiet();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || outstanding || pr_ph != 0) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check("drain_timeout", (w < 3000) ? 1 : 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic set_busy(input bit b);
    @(posedge clk);
    #2 force_busy = b;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_push"}, bus.push, 0);
    check({tag, "_pages"}, bus.pages, 0);
    check({tag, "_queued"}, queued, 0);
    check({tag, "_job_ready"}, bus.job_ready, 1);
    check({tag, "_pulses"}, {job_done, start_err, zero_job}, 0);
    check({tag, "_pages_printed"}, pages_printed, 0);
  endtask

  initial begin
    int d0;
    bus.job_valid = 1'b0;
    bus.job_pages = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Single 3-page job
    enqueue(3);
    wait_quiet();
    check("t1_pages_printed", pages_printed, 3);

    // Fill with the printer busy; fifth job waits for the first dispatch
    set_busy(1'b1);
    for (int i = 1; i <= 4; i++) enqueue(i);
    @(negedge clk);
    bus.job_valid = 1'b1;
    bus.job_pages = 8'd5;
    for (int i = 0; i < 4; i++) begin
      check("full_not_ready", bus.job_ready, 0);
      @(negedge clk);
    end
    bus.job_valid = 1'b0;
    set_busy(1'b0);
    enqueue(5);
    wait_quiet();

    // Zero-page job is discarded
    enqueue(0);
    enqueue(2);
    wait_quiet();

    // Silent printer: first job times out, second is then dispatched
    silent = 1'b1;
    set_busy(1'b1);
    enqueue(4);
    enqueue(6);
    set_busy(1'b0);
    d0 = dispatched;
    for (int w = 0; w < 100 && dispatched == d0; w++) @(negedge clk);
    repeat (2) @(negedge clk);
    silent = 1'b0;
    wait_quiet();

    // Enqueue lands on the pop edge with two jobs queued
    set_busy(1'b1);
    enqueue(7);
    enqueue(8);
    set_busy(1'b0);
    @(negedge clk);
    enqueue(9);
    enqueue(1);
    wait_quiet();

    // Async reset while printing with two jobs still queued
    enqueue(5);
    enqueue(6);
    enqueue(7);
    for (int w = 0; w < 200 && !(pr_ph == 3 && queued == 2); w++) @(negedge clk);
    check("t6_reached_wait_done", (pr_ph == 3 && queued == 2) ? 1 : 0, 1);
    #2 rst_n = 1'b0;
    mon_en = 1'b0;
    #1 check_reset_outputs("async_reset");
    exp_q.delete();
    accepted_nz = 0; dispatched = 0; outstanding = 1'b0; zero_due = 1'b0;
    exp_pp = 0; last_pages = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (30) @(negedge clk);
    check("no_push_after_reset", queued, 0);

    // Randomized traffic with occasional busy bursts
    for (int n = 0; n < 40; n++) begin
      enqueue($urandom_range(0, 6));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 4) == 0) begin
        set_busy(1'b1);
        repeat ($urandom_range(1, 8)) @(negedge clk);
        set_busy(1'b0);
      end
    end
    wait_quiet();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/print_job_queue.md
Name: print_job_queue

Overview:
- Upstream feeder for the printer controller stage: buffers incoming print jobs (page counts) in a small FIFO and dispatches them one at a time.
- Per job, it issues a one-cycle push with a stable pages value, then tracks the printer through start and completion using the printer's warm/loadpage/printpage status outputs.
- Also keeps a running count of printed pages and flags jobs that never start.

Parameters:
- DEPTH, 4, number of queued jobs (power of 2, >=2)
- PAGE_W, 8, width of a job page count (matches printer pages input)
- START_TIMEOUT, 255, max cycles from push to first printer activity before the job is declared lost
- CNT_W, 16, width of printed-page counter

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- job_valid  in  1  new job offered
- job_pages  in  PAGE_W  page count of offered job
- job_ready  out  1  queue can accept a job this cycle
- warm  in  1  printer status: warming
- loadpage  in  1  printer status: loading page
- printpage  in  1  printer status: printing page (one cycle per page)
- push  out  1  one-cycle job start pulse to printer
- pages  out  PAGE_W  page count presented to printer
- queued  out  clog2(DEPTH)+1  jobs currently held in FIFO
- job_done  out  1  one-cycle pulse when the dispatched job completes
- start_err  out  1  one-cycle pulse when a dispatched job times out
- zero_job  out  1  one-cycle pulse when a zero-page job is discarded
- pages_printed  out  CNT_W  total printpage cycles since reset, wraps

Behaviour:
- Reset (async, rst_n low): FIFO empty, FSM IDLE, push=0, pages=0, queued=0, all pulses 0, pages_printed=0, timeout counter 0. Reset mid-job drops all queued and in-flight jobs.
- Enqueue: job_ready = (queued != DEPTH). Handshake completes when job_valid & job_ready at posedge clk.
  - job_pages == 0: the job is not stored and zero_job pulses the next cycle.
  - Otherwise the job is written at the tail.
- Simultaneous enqueue and dequeue in one cycle is allowed. queued is then unchanged. When full, job_ready stays low even if a pop occurs that cycle.
- printer_idle = ~(warm | loadpage | printpage).
- FSM states:
  - IDLE: if queued != 0 and printer_idle -> ISSUE.
  - ISSUE (1 cycle): push=1; pages <= head entry (registered, so it is valid in the same cycle push is high); pop FIFO; clear timeout counter -> WAIT_START.
  - WAIT_START: if ~printer_idle -> WAIT_DONE. Otherwise increment the timeout counter. On reaching START_TIMEOUT: pulse start_err, job discarded -> IDLE.
  - WAIT_DONE: when printer_idle -> IDLE, with job_done pulsing on the cycle of that transition.
- pages holds its value after push drops until the next ISSUE. push is never high on two consecutive cycles.
- Latency: job written into an empty queue with an idle printer: push asserts 2 cycles after the accepting edge (IDLE sees queued != 0 on the next cycle, then ISSUE).
- pages_printed increments on every clk where printpage=1, in any state, and wraps modulo 2^CNT_W.
- Printer activity seen in IDLE (not caused by this block) blocks dispatch until printer_idle. It does not affect FSM state.
- Outputs push, pages, pulses and pages_printed are all registered.

Decomposition:
- Shared package print_pkg:
  - FSM state enum: IDLE, ISSUE, WAIT_START, WAIT_DONE.
  - Printer status localparams: SLEEPING/WARMING/LOADING/PRINTING encodings, shared with the printer controller.
  - Default PAGE_W.
- One sub-module: job_fifo.
  - Synchronous FIFO, DEPTH x PAGE_W, async reset.
  - Pointer wrap-around via an extra MSB.
  - Outputs full/empty/count.
- The dispatch FSM, timeout counter and page counter live in print_job_queue.

Test Plan:
1. Reset, enqueue 3 pages, printer model asserts warm 2 cycles after push, prints 3 pages, then goes idle -> push high exactly 1 cycle with pages=3; pages_printed=3; job_done pulses once; queued returns to 0.
2. Enqueue 5 jobs (1,2,3,4,5) back-to-back with the printer held busy -> first 4 accepted, job_ready=0 on the 5th until the first ISSUE. Dispatch order is 1,2,3,4,5, each push only after printer_idle.
3. Enqueue job_pages=0, then 2 -> zero_job pulses once, queued=1, single push with pages=2.
4. Printer model never responds to push -> start_err pulses START_TIMEOUT cycles after WAIT_START entry. FSM returns to IDLE and dispatches the next queued job.
5. Enqueue and dequeue in the same cycle with queued=2 -> queued stays 2 and FIFO contents are in correct order.
6. Assert rst_n low during WAIT_DONE with 2 jobs queued -> all outputs return to reset values immediately (async). No push after release until a new job is enqueued.
